// File: rtl/spi_flash_responder.sv
// SPI flash target emulator: serves 0x03 single and 0x6B quad reads
// from a byte-wide synchronous memory, oversampling the host pins.
module spi_flash_responder #(
  parameter int ADDR_BITS  = 16,
  parameter int DUMMY_CLKS = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 spi_clk_in,
  input  logic                 spi_select_in,
  input  logic [3:0]           spi_data_in,
  output logic [3:0]           spi_data_out,
  output logic [3:0]           spi_data_oe,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_rd,
  input  logic [7:0]           mem_data,
  output logic                 active,
  output logic                 cmd_error
);

  localparam int CW = $clog2(ADDR_BITS + DUMMY_CLKS + 8) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_IGN
  } state_e;

  logic [1:0] sck_sq, cs_sq, mosi_sq;
  logic       sck_q;
  logic       sck_s, cs_s, mosi_s, rise, fall;
  logic       unused_io;

  assign unused_io = ^spi_data_in[3:1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sck_sq  <= 2'b00;
      cs_sq   <= 2'b11;
      mosi_sq <= 2'b00;
      sck_q   <= 1'b0;
    end else begin
      sck_sq  <= {sck_sq[0], spi_clk_in};
      cs_sq   <= {cs_sq[0], spi_select_in};
      mosi_sq <= {mosi_sq[0], spi_data_in[0]};
      sck_q   <= sck_sq[1];
    end
  end

  assign sck_s  = sck_sq[1];
  assign cs_s   = cs_sq[1];
  assign mosi_s = mosi_sq[1];
  assign rise   = sck_s & ~sck_q;
  assign fall   = ~sck_s & sck_q;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [6:0]           cmd_q, cmd_d;
  logic [ADDR_BITS-2:0] ash_q, ash_d;
  logic                 quad_q, quad_d;
  logic [7:0]           obyte_q, obyte_d;
  logic [7:0]           nbyte_q, nbyte_d;
  logic [2:0]           pos_q, pos_d;
  logic                 rdp_q, rdp_d;
  logic [3:0]           dout_q, dout_d;
  logic [3:0]           oe_q, oe_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 rd_q, rd_d;
  logic                 act_q, act_d;
  logic                 err_q, err_d;
  logic [7:0]           cmd_n;
  logic [7:0]           cur;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      ash_q   <= '0;
      quad_q  <= 1'b0;
      obyte_q <= '0;
      nbyte_q <= '0;
      pos_q   <= '0;
      rdp_q   <= 1'b0;
      dout_q  <= '0;
      oe_q    <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      act_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      ash_q   <= ash_d;
      quad_q  <= quad_d;
      obyte_q <= obyte_d;
      nbyte_q <= nbyte_d;
      pos_q   <= pos_d;
      rdp_q   <= rdp_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      act_q   <= act_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    ash_d   = ash_q;
    quad_d  = quad_q;
    obyte_d = obyte_q;
    nbyte_d = nbyte_q;
    pos_d   = pos_q;
    rdp_d   = rd_q;
    dout_d  = dout_q;
    oe_d    = oe_q;
    addr_d  = addr_q;
    rd_d    = 1'b0;
    act_d   = act_q;
    err_d   = 1'b0;
    cmd_n   = {cmd_q, mosi_s};
    // bypass so a byte arriving on the same clk as a fall is not missed
    cur     = rdp_q ? mem_data : nbyte_q;
    if (rdp_q)
      nbyte_d = mem_data;
    if (cs_s) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      nbyte_d = '0;
      pos_d   = '0;
      rdp_d   = 1'b0;
      dout_d  = '0;
      oe_d    = '0;
      act_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_CMD;
          cnt_d   = CW'(7);
        end
        S_CMD: if (rise) begin
          act_d = 1'b1;
          cmd_d = cmd_n[6:0];
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) begin
            if (cmd_n == 8'h03 || cmd_n == 8'h6B) begin
              state_d = S_ADDR;
              cnt_d   = CW'(ADDR_BITS - 1);
              quad_d  = (cmd_n == 8'h6B);
            end else begin
              state_d = S_IGN;
              err_d   = 1'b1;
            end
          end
        end
        S_ADDR: if (rise) begin
          ash_d = {ash_q[ADDR_BITS-3:0], mosi_s};
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) begin
            addr_d = {ash_q, mosi_s};
            rd_d   = 1'b1;
            pos_d  = '0;
            if (quad_q && DUMMY_CLKS != 0) begin
              state_d = S_DUMMY;
              cnt_d   = CW'(DUMMY_CLKS);
            end else begin
              state_d = S_DATA;
            end
          end
        end
        S_DUMMY: if (rise) begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1))
            state_d = S_DATA;
        end
        S_DATA: if (fall) begin
          oe_d = quad_q ? 4'b1111 : 4'b0010;
          if (pos_q == '0) begin
            obyte_d = cur;
            addr_d  = addr_q + 1'b1;
            rd_d    = 1'b1;
            dout_d  = quad_q ? cur[7:4] : {2'b00, cur[7], 1'b0};
          end else begin
            dout_d = quad_q ? obyte_q[3:0]
                            : {2'b00, obyte_q[3'd7 - pos_q], 1'b0};
          end
          pos_d = (quad_q && pos_q == 3'd1) ? 3'd0 : pos_q + 3'd1;
        end
        S_IGN: oe_d = '0;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign spi_data_out = dout_q;
  assign spi_data_oe  = oe_q;
  assign mem_addr     = addr_q;
  assign mem_rd       = rd_q;
  assign active       = act_q;
  assign cmd_error    = err_q;

endmodule
